oka_clmul_pipe: RTL and testbench

Pipelined, parametrised carry-less (GF(2)[x]) multiplier built on a one-level Karatsuba split, with an optional modular-reduction stage that yields GF(2^W) products. It is the clocked, width-generic successor to the fixed 8-bit combinational carry-less multiplier. It sits between a valid/ready operand source and a valid/ready result sink, accepts one operand pair per cycle, and applies backpressure without losing or duplicating results.

---
 rtl/oka_clmul_pipe_pkg.sv | 48 ++++
 rtl/oka_clmul_pipe_if.sv | 32 +++
 rtl/oka_clmul_pipe_clmul_half.sv | 27 ++
 rtl/oka_clmul_pipe.sv | 132 +++++++++++++
 tb/tb_oka_clmul_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oka_clmul_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : oka_pkg                                                       |
// | Purpose  : Shared constants and helpers for the Karatsuba carry-less     |
// |            multiplier pipeline: a generic carry-less multiply, a GF(2^w) |
// |            reduction, the AES field polynomial and an operand-width      |
// |            legality check.                                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package oka_pkg;

  // Lower byte of x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_POLY = 8'h1B;

  // Widest operand the helper functions can handle.
  localparam int MAXW = 64;

  // Generic carry-less product of the low n bits of x and y.
  function automatic logic [2*MAXW-1:0] clmul(input logic [MAXW-1:0] x,
                                              input logic [MAXW-1:0] y,
                                              input int              n);
    logic [2*MAXW-1:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      if (y[i]) acc = acc ^ ({{MAXW{1'b0}}, x} << i);
    end
    return acc;
  endfunction

  // Reduce a (2w-1)-bit carry-less product modulo x^w + poly.
  function automatic logic [MAXW-1:0] gf_reduce(input logic [2*MAXW-1:0] p,
                                                input logic [MAXW-1:0]   poly,
                                                input int                w);
    logic [2*MAXW-1:0] t;
    t = p;
    for (int k = 2*w-2; k >= w; k--) begin
      if (t[k]) t = t ^ ({{MAXW{1'b0}}, poly} << (k-w)) ^ ({{(2*MAXW-1){1'b0}}, 1'b1} << k);
    end
    return t[MAXW-1:0];
  endfunction

  // Karatsuba split needs an even width with non-trivial halves.
  function automatic bit w_ok(input int w);
    return (w >= 4) && ((w % 2) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/oka_clmul_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : oka_clmul_pipe_if                                             |
// | Purpose  : Valid/ready operand and result bundle for oka_clmul_pipe.     |
// |   in_valid/in_ready/a/b  : operand pair handshake (source -> block)      |
// |   out_valid/out_ready/y  : product handshake (block -> sink)             |
// |   master : view of the environment driving operands / sinking results    |
// |   slave  : view of the multiplier                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface oka_clmul_pipe_if #(
  parameter int W = 8
) ();
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-2:0] y;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y
  );
endinterface
`default_nettype wire

// File: rtl/oka_clmul_pipe_clmul_half.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clmul_half                                                    |
// | Purpose  : Combinational N x N carry-less (GF(2)[x]) multiplier.         |
// |   x, y : N-bit operands, bit i is the coefficient of x^i                 |
// |   p    : 2N-1 bit product                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clmul_half #(
  parameter int N = 4
) (
  input  wire  [N-1:0]   x,
  input  wire  [N-1:0]   y,
  output logic [2*N-2:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        p[i+j] = p[i+j] ^ (x[i] & y[j]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/oka_clmul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : oka_clmul_pipe                                                |
// | Purpose  : Pipelined one-level Karatsuba carry-less multiplier with an   |
// |            optional GF(2^W) reduction stage.                             |
// |   clk   : rising-edge clock                                              |
// |   rst_n : asynchronous active-low reset                                  |
// |   bus   : slave side of oka_clmul_pipe_if (operands in, product out)     |
// |   W      : operand width (even, >= 4)                                    |
// |   REDUCE : 0 = raw 2W-1 bit product, 1 = reduced mod x^W + POLY          |
// |   POLY   : low W bits of the reduction polynomial                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module oka_clmul_pipe
  import oka_pkg::*;
#(
  parameter int           W      = 8,
  parameter int           REDUCE = 0,
  parameter logic [W-1:0] POLY   = W'(AES_POLY)
) (
  input wire              clk,
  input wire              rst_n,
  oka_clmul_pipe_if.slave bus
);

  localparam int H  = W / 2;
  localparam int HP = 2*H - 1;
  localparam int PW = 2*W - 1;
  localparam int NS = (REDUCE != 0) ? 3 : 2;

  if (!w_ok(W)) begin : g_bad_width
    $error("oka_clmul_pipe: W must be even and at least 4");
  end

  // ---------------------------------------------------------------- control
  logic [NS-1:0] w_valid;  // occupancy of each stage
  logic [NS-1:0] w_down;   // downstream of stage s takes data this cycle
  logic [NS-1:0] w_space;  // stage s can take new data this cycle
  logic [NS-1:0] w_upv;    // upstream of stage s holds valid data
  logic [NS-1:0] w_load;

  // A stage has room when empty or when its occupant moves on this cycle;
  // the chain resolves from the sink back to the source.
  always_comb begin
    w_down  = '0;
    w_space = '0;
    w_down[NS-1] = bus.out_ready;
    for (int s = NS-1; s >= 1; s--) begin
      w_space[s]  = ~w_valid[s] | w_down[s];
      w_down[s-1] = w_space[s];
    end
    w_space[0] = ~w_valid[0] | w_down[0];
  end

  assign w_upv  = {w_valid[NS-2:0], bus.in_valid};
  assign w_load = w_upv & w_space;

  for (genvar s = 0; s < NS; s++) begin : g_stage
    logic r_v;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_v <= 1'b0;
      else        r_v <= w_load[s] | (r_v & ~w_down[s]);
    end
    assign w_valid[s] = r_v;
  end

  assign bus.in_ready  = w_space[0];
  assign bus.out_valid = w_valid[NS-1];

  // ------------------------------------------------ stage 1: half products
  logic [H-1:0]  w_asum, w_bsum;
  logic [HP-1:0] w_p0, w_p1, w_p2;
  logic [HP-1:0] r_p0, r_p1, r_p2;

  assign w_asum = bus.a[H-1:0] ^ bus.a[W-1:H];
  assign w_bsum = bus.b[H-1:0] ^ bus.b[W-1:H];

  clmul_half #(.N(H)) u_p0 (.x(bus.a[H-1:0]), .y(bus.b[H-1:0]), .p(w_p0));
  clmul_half #(.N(H)) u_p2 (.x(bus.a[W-1:H]), .y(bus.b[W-1:H]), .p(w_p2));
  clmul_half #(.N(H)) u_p1 (.x(w_asum),       .y(w_bsum),       .p(w_p1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0 <= '0;
      r_p1 <= '0;
      r_p2 <= '0;
    end else if (w_load[0]) begin
      r_p0 <= w_p0;
      r_p1 <= w_p1;
      r_p2 <= w_p2;
    end
  end

  // ---------------------------------------------------- stage 2: combine
  // The middle term is the cross product aL*bH ^ aH*bL recovered from P1.
  logic [HP-1:0] w_mid;
  logic [PW-1:0] w_prod;
  logic [PW-1:0] r_prod;

  assign w_mid  = r_p1 ^ r_p0 ^ r_p2;
  assign w_prod = PW'(r_p0) ^ (PW'(w_mid) << H) ^ (PW'(r_p2) << W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_prod <= '0;
    else if (w_load[1]) r_prod <= w_prod;
  end

  // -------------------------------------------- stage 3: optional reduce
  if (REDUCE != 0) begin : g_reduce
    logic [PW-1:0] w_t;
    logic [W-1:0]  r_red;

    // Fold the high coefficients down from the top; x^k == x^(k-W)*POLY.
    always_comb begin
      w_t = r_prod;
      for (int k = PW-1; k >= W; k--) begin
        if (w_t[k]) w_t = w_t ^ (PW'(POLY) << (k-W)) ^ (PW'(1) << k);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_red <= '0;
      else if (w_load[2]) r_red <= w_t[W-1:0];
    end

    assign bus.y = {{(W-1){1'b0}}, r_red};
  end else begin : g_raw
    assign bus.y = r_prod;
  end

endmodule
`default_nettype wire

// File: tb/tb_oka_clmul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_oka_clmul_pipe                                             |
// | Purpose  : Self-checking bench for oka_clmul_pipe in three builds:       |
// |            d0 = W8 raw, d1 = W8 reduced (AES), d2 = W16 reduced (0x2B).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_oka_clmul_pipe;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  oka_clmul_pipe_if #(.W(8))  bus0 ();
  oka_clmul_pipe_if #(.W(8))  bus1 ();
  oka_clmul_pipe_if #(.W(16)) bus2 ();

  oka_clmul_pipe #(.W(8),  .REDUCE(0), .POLY(8'h1B))
    u_d0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  oka_clmul_pipe #(.W(8),  .REDUCE(1), .POLY(8'h1B))
    u_d1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  oka_clmul_pipe #(.W(16), .REDUCE(1), .POLY(16'h002B))
    u_d2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: schoolbook product for raw mode; for reduced mode a
  // Horner-style multiply where every doubling is reduced immediately.
  function automatic logic [30:0] ref_mul(input int w, input bit red,
                                          input logic [15:0] poly,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] r, mask, am, bm;
    logic        carry;
    mask = (w == 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
    am = a & mask;
    bm = b & mask;
    if (!red) begin
      p = '0;
      for (int i = 0; i < w; i++) if (bm[i]) p = p ^ ({16'b0, am} << i);
      return p[30:0];
    end
    r = '0;
    for (int i = w-1; i >= 0; i--) begin
      carry = r[w-1];
      r = (r << 1) & mask;
      if (carry) r = r ^ poly;
      if (bm[i]) r = r ^ am;
    end
    return {15'b0, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ DUT access helpers
  function automatic logic get_ov(input int d);
    case (d)
      0:       return bus0.out_valid;
      1:       return bus1.out_valid;
      default: return bus2.out_valid;
    endcase
  endfunction

  function automatic logic get_ir(input int d);
    case (d)
      0:       return bus0.in_ready;
      1:       return bus1.in_ready;
      default: return bus2.in_ready;
    endcase
  endfunction

  function automatic logic [30:0] get_y(input int d);
    case (d)
      0:       return 31'(bus0.y);
      1:       return 31'(bus1.y);
      default: return bus2.y;
    endcase
  endfunction

  task automatic drive(input int d, input logic v, input logic [15:0] a, input logic [15:0] b);
    case (d)
      0:       begin bus0.in_valid = v; bus0.a = a[7:0]; bus0.b = b[7:0]; end
      1:       begin bus1.in_valid = v; bus1.a = a[7:0]; bus1.b = b[7:0]; end
      default: begin bus2.in_valid = v; bus2.a = a;      bus2.b = b;      end
    endcase
  endtask

  task automatic set_or(input int d, input logic r);
    case (d)
      0:       bus0.out_ready = r;
      1:       bus1.out_ready = r;
      default: bus2.out_ready = r;
    endcase
  endtask

  // ------------------------------------------ scoreboards (sampled at negedge)
  logic [30:0] q0[$], q1[$], q2[$];

  always @(negedge clk) begin
    if (!rst_n) q0.delete();
    else begin
      if (bus0.in_valid && bus0.in_ready) q0.push_back(ref_mul(8, 1'b0, 16'h0, 16'(bus0.a), 16'(bus0.b)));
      if (bus0.out_valid && bus0.out_ready) begin
        if (q0.size() == 0) check("d0 unexpected result", 32'(bus0.y), 32'hFFFF_FFFF);
        else                check("d0 stream result", 32'(bus0.y), 32'(q0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) q1.delete();
    else begin
      if (bus1.in_valid && bus1.in_ready) q1.push_back(ref_mul(8, 1'b1, 16'h1B, 16'(bus1.a), 16'(bus1.b)));
      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) check("d1 unexpected result", 32'(bus1.y), 32'hFFFF_FFFF);
        else                check("d1 stream result", 32'(bus1.y), 32'(q1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) q2.delete();
    else begin
      if (bus2.in_valid && bus2.in_ready) q2.push_back(ref_mul(16, 1'b1, 16'h002B, bus2.a, bus2.b));
      if (bus2.out_valid && bus2.out_ready) begin
        if (q2.size() == 0) check("d2 unexpected result", 32'(bus2.y), 32'hFFFF_FFFF);
        else                check("d2 stream result", 32'(bus2.y), 32'(q2.pop_front()));
      end
    end
  end

  // ------------------------------------------------------------ sequences
  // Called at posedge+1 with the DUT idle. lat counts clock edges from the
  // accept edge (inclusive) until out_valid is seen high.
  task automatic single(input int d, input logic [15:0] a, input logic [15:0] b,
                        output logic [30:0] y, output int lat);
    set_or(d, 1'b1);
    drive(d, 1'b1, a, b);
    @(negedge clk);
    check($sformatf("d%0d idle in_ready", d), 32'(get_ir(d)), 32'd1);
    @(posedge clk); #1;
    drive(d, 1'b0, 16'h0, 16'h0);
    lat = 1;
    while (!get_ov(d) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    y = get_y(d);
  endtask

  task automatic stream(input int d, input int n, input bit exh);
    int first = -1;
    int last  = -1;
    int seen  = 0;
    int sent  = 0;
    logic [15:0] a, b;
    set_or(d, 1'b1);
    a = exh ? 16'd1    : 16'($urandom());
    b = exh ? 16'hFFFF : 16'($urandom());
    for (int cyc = 0; cyc < n + 20; cyc++) begin
      drive(d, sent < n, a, b);
      @(negedge clk);
      if (sent < n) begin
        check($sformatf("d%0d stream in_ready", d), 32'(get_ir(d)), 32'd1);
        if (get_ir(d)) begin
          sent++;
          a = exh ? 16'(sent + 1) : 16'($urandom());
          b = exh ? 16'hFFFF      : 16'($urandom());
        end
      end
      if (get_ov(d)) begin
        if (first < 0) first = cyc;
        last = cyc;
        seen++;
      end
      @(posedge clk); #1;
    end
    check($sformatf("d%0d stream result count", d), 32'(seen), 32'(n));
    check($sformatf("d%0d stream no bubbles", d), 32'(last - first + 1), 32'(n));
  endtask

  typedef struct {
    int          d;
    logic [15:0] a;
    logic [15:0] b;
    logic [30:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [30:0] y, y_hold;
    int          lat, acc, waited;
    logic [15:0] a, b;

    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{0, 16'h0053, 16'h00CA, 31'h3F7E};
    vecs[1]  = '{0, 16'h00FF, 16'h00FF, 31'h5555};
    vecs[2]  = '{0, 16'h0080, 16'h0080, 31'h4000};
    vecs[3]  = '{0, 16'h0000, 16'h005A, 31'h0000};
    vecs[4]  = '{1, 16'h0053, 16'h00CA, 31'h0001};
    vecs[5]  = '{1, 16'h0002, 16'h0080, 31'h001B};
    vecs[6]  = '{1, 16'h0000, 16'h00A7, 31'h0000};
    vecs[7]  = '{1, 16'h0001, 16'h0053, 31'h0053};
    vecs[8]  = '{2, 16'h8000, 16'h0002, 31'h002B};
    vecs[9]  = '{2, 16'h0001, 16'hFFFF, 31'hFFFF};
    vecs[10] = '{2, 16'h0002, 16'h8000, 31'h002B};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 16'h0, 16'h0);
      set_or(d, 1'b1);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d reset out_valid", d), 32'(get_ov(d)), 32'd0);
      check($sformatf("d%0d reset y", d), 32'(get_y(d)), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d in_ready after reset", d), 32'(get_ir(d)), 32'd1);
    @(posedge clk); #1;

    check("pkg clmul", 32'(oka_pkg::clmul(64'h53, 64'hCA, 8)), 32'h3F7E);
    check("pkg gf_reduce", 32'(oka_pkg::gf_reduce(oka_pkg::clmul(64'h53, 64'hCA, 8), 64'h1B, 8)), 32'h01);

    // Directed vectors with latency measurement.
    for (int i = 0; i < 11; i++) begin
      single(vecs[i].d, vecs[i].a, vecs[i].b, y, lat);
      check($sformatf("vec%0d y", i), 32'(y), 32'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 32'(lat), (vecs[i].d == 0) ? 32'd2 : 32'd3);
    end
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back streams.
    stream(0, 100, 1'b0);
    stream(1, 100, 1'b0);
    stream(2, 255, 1'b1);

    // Backpressure on the reduced 8-bit build.
    set_or(1, 1'b0);
    acc = 0;
    y_hold = '0;
    a = 16'($urandom());
    b = 16'($urandom());
    for (int c = 0; c < 10; c++) begin
      drive(1, 1'b1, a, b);
      @(negedge clk);
      if (get_ir(1)) begin
        acc++;
        a = 16'($urandom());
        b = 16'($urandom());
      end
      if (c == 4) y_hold = get_y(1);
      @(posedge clk); #1;
    end
    check("stall accepted pairs", 32'(acc), 32'd3);
    check("stall in_ready low", 32'(get_ir(1)), 32'd0);
    check("stall out_valid held", 32'(get_ov(1)), 32'd1);
    check("stall y stable", 32'(get_y(1)), 32'(y_hold));
    drive(1, 1'b0, 16'h0, 16'h0);
    set_or(1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("release out_valid cycle %0d", c), 32'(get_ov(1)), (c < 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end

    // Asynchronous reset with two results in flight.
    set_or(1, 1'b0);
    drive(1, 1'b1, 16'h53, 16'hCA);
    @(posedge clk); #1;
    drive(1, 1'b1, 16'h02, 16'h80);
    @(posedge clk); #1;
    drive(1, 1'b0, 16'h0, 16'h0);
    waited = 0;
    while (!get_ov(1) && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check("pre-reset out_valid", 32'(get_ov(1)), 32'd1);
    check("pre-reset y", 32'(get_y(1)), 32'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(get_ov(1)), 32'd0);
    check("async reset y", 32'(get_y(1)), 32'd0);
    check("async reset in_ready", 32'(get_ir(1)), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    set_or(1, 1'b1);
    @(posedge clk); #1;
    single(1, 16'h02, 16'h80, y, lat);
    check("post-reset y", 32'(y), 32'h1B);
    check("post-reset latency", 32'(lat), 32'd3);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
